// File: rtl/ascon_pack.sv
// Shared types, FSM encoding and helpers for the ASCON permutation engine.
package ascon_pack;

  typedef logic [4:0][63:0] type_state;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [3:0] ROUNDS_6   = 4'd6;
  localparam logic [3:0] ROUNDS_8   = 4'd8;
  localparam logic [3:0] ROUNDS_12  = 4'd12;
  localparam logic [3:0] ROUNDS_MAX = 4'd12;

  function automatic logic [7:0] round_const(input logic [3:0] idx);
    return {4'hF - idx, idx};
  endfunction

  // A run must be a legal length and split evenly into unrolled clock cycles.
  function automatic logic rounds_ok(input logic [3:0] nb, input int unroll);
    logic legal;
    legal = (nb == ROUNDS_6) || (nb == ROUNDS_8) || (nb == ROUNDS_12);
    return legal && ((int'(nb) % unroll) == 0);
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, bitsliced S-box, linear diffusion.
module ascon_round
  import ascon_pack::*;
(
  input  type_state  state,
  input  logic [3:0] round,
  output type_state  next
);

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic type_state round_f(input type_state s, input logic [3:0] idx);
    type_state   r;
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'd0, round_const(idx)};
    x3 = s[3];
    x4 = s[4];
    // S-box applied to all 64 five-bit columns at once
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    r[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    r[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    r[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    r[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    r[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return r;
  endfunction

  assign next = round_f(state, round);

endmodule

// File: rtl/ascon_perm_engine.sv
// Iterative ASCON permutation with begin/end absorb and key stages, UNROLL rounds per clock.
module ascon_perm_engine
  import ascon_pack::*;
#(
  parameter int UNROLL    = 1,
  parameter int RATE_BITS = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [3:0]           nb_rounds_i,
  input  logic                 load_i,
  input  type_state            state_i,
  input  logic [RATE_BITS-1:0] data_i,
  input  logic                 en_xor_data_i,
  input  logic                 en_replace_data_i,
  input  logic                 en_xor_key_begin_i,
  input  logic                 en_xor_key_end_i,
  input  logic                 en_xor_lsb_end_i,
  input  logic [127:0]         key_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output type_state            state_o,
  output logic [RATE_BITS-1:0] cipher_o,
  output logic [127:0]         tag_o
);

  localparam int RATE_WORDS = RATE_BITS / 64;

  fsm_t                 fsm;
  logic [3:0]           round_idx;
  logic [127:0]         key_q;
  logic                 key_end_q;
  logic                 lsb_end_q;
  logic                 start_ok;
  logic                 last_run;
  type_state            begin_state;
  type_state            final_state;
  logic [RATE_BITS-1:0] cipher_d;
  type_state            chain [UNROLL+1];

  assign start_ok = start_i && rounds_ok(nb_rounds_i, UNROLL);
  assign last_run = ({1'b0, round_idx} + 5'(UNROLL)) >= 5'd12;

  // Replace mode still reports old-rate XOR data, so decryption yields plaintext on cipher_o.
  always_comb begin
    begin_state = load_i ? state_i : state_o;
    cipher_d    = '0;
    for (int w = 0; w < RATE_WORDS; w++) begin
      cipher_d[RATE_BITS-1-64*w -: 64] = begin_state[w] ^
        ((en_xor_data_i || en_replace_data_i) ? data_i[RATE_BITS-1-64*w -: 64] : 64'h0);
      begin_state[w] = en_replace_data_i ? data_i[RATE_BITS-1-64*w -: 64]
                                         : cipher_d[RATE_BITS-1-64*w -: 64];
    end
    if (en_xor_key_begin_i) begin
      begin_state[RATE_WORDS]   = begin_state[RATE_WORDS]   ^ key_i[127:64];
      begin_state[RATE_WORDS+1] = begin_state[RATE_WORDS+1] ^ key_i[63:0];
    end
  end

  assign chain[0] = state_o;

  for (genvar k = 0; k < UNROLL; k++) begin : g_round
    ascon_round u_round (
      .state (chain[k]),
      .round (round_idx + 4'(k)),
      .next  (chain[k+1])
    );
  end

  always_comb begin
    final_state = chain[UNROLL];
    if (last_run && key_end_q) begin
      final_state[3] = final_state[3] ^ key_q[127:64];
      final_state[4] = final_state[4] ^ key_q[63:0];
    end
    if (last_run && lsb_end_q) begin
      final_state[4][0] = ~final_state[4][0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm       <= IDLE;
      state_o   <= '0;
      cipher_o  <= '0;
      tag_o     <= '0;
      round_idx <= '0;
      key_q     <= '0;
      key_end_q <= 1'b0;
      lsb_end_q <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      error_o   <= 1'b0;
    end else begin
      done_o  <= 1'b0;
      error_o <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start_ok) begin
            state_o   <= begin_state;
            cipher_o  <= cipher_d;
            round_idx <= ROUNDS_MAX - nb_rounds_i;
            key_q     <= key_i;
            key_end_q <= en_xor_key_end_i;
            lsb_end_q <= en_xor_lsb_end_i;
            busy_o    <= 1'b1;
            fsm       <= RUN;
          end else if (start_i) begin
            error_o <= 1'b1;
          end
        end
        RUN: begin
          state_o <= final_state;
          if (last_run) fsm <= DONE;
          else round_idx <= round_idx + 4'(UNROLL);
        end
        DONE: begin
          tag_o  <= {state_o[3], state_o[4]};
          done_o <= 1'b1;
          busy_o <= 1'b0;
          fsm    <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ascon_perm_engine.md
ASCON_PERM_ENGINE -- requirements
Module: ascon_perm_engine

Interface
REQ-001 Parameter UNROLL, default 1, number of ASCON rounds computed per clock; legal values are 1, 2, 3, 6.
REQ-002 Parameter RATE_BITS, default 64, rate width in bits; legal values are 64 (Ascon-128) and 128 (Ascon-128a).
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 start_i  in  1  launch one permutation; sampled only in IDLE.
REQ-006 nb_rounds_i  in  4  round count for this run; legal values are 6, 8, 12.
REQ-007 load_i  in  1  1 selects state_i as the starting state; 0 selects the internal state register.
REQ-008 state_i  in  type_state  external starting state.
REQ-009 data_i  in  RATE_BITS  AD/plaintext/ciphertext block, MSB-aligned onto the rate.
REQ-010 en_xor_data_i, en_replace_data_i, en_xor_key_begin_i, en_xor_key_end_i, en_xor_lsb_end_i  in  1 each  per-run operation enables; sampled with start_i.
REQ-011 key_i  in  128  key.
REQ-012 busy_o  out  1  high from the cycle after an accepted start until done_o.
REQ-013 done_o  out  1  one-cycle pulse when state_o holds the final result.
REQ-014 error_o  out  1  one-cycle pulse when a start is rejected.
REQ-015 state_o  out  type_state  internal state register.
REQ-016 cipher_o  out  RATE_BITS  rate after the begin-xor, captured at an accepted start.
REQ-017 tag_o  out  128  {x3,x4} after the end-xor, captured at done.

Function
REQ-018 FSM states are IDLE, RUN and DONE; all outputs are registered.
REQ-019 IDLE to RUN on start_i with a legal nb_rounds_i that is divisible by UNROLL.
REQ-020 IDLE with start_i and an illegal round count: error_o pulses for one cycle, no register changes, and the FSM stays in IDLE.
REQ-021 Begin stage, applied once on the start cycle, in this order: source mux (load_i), then data_i XOR into the rate (en_xor_data_i) or data_i copied into the rate (en_replace_data_i, which has priority), then key XOR into the two words following the rate (x1,x2 for RATE 64; x2,x3 for RATE 128).
REQ-022 The begin stage never XORs key_i into the rate words.
REQ-023 cipher_o latches the post-XOR rate at the start cycle.
REQ-024 Round index i starts at 12-nb_rounds_i and advances by UNROLL each RUN cycle.
REQ-025 Round constant is {4'hF-i[3:0], i[3:0]}, XORed into x2[7:0].
REQ-026 Each round applies constant addition, S-box layer and linear diffusion per the ASCON spec.
REQ-027 RUN lasts nb_rounds_i/UNROLL cycles, so done_o asserts nb_rounds_i/UNROLL+1 cycles after the start edge.
REQ-028 End stage, on the last RUN cycle only: key XOR into {x3,x4} (en_xor_key_end_i), then x4[0] ^= 1 (en_xor_lsb_end_i).
REQ-029 DONE lasts exactly one cycle, asserts done_o, latches tag_o, then returns to IDLE.
REQ-030 start_i while in RUN or DONE is ignored, with no error.
REQ-031 A new start is accepted in the cycle after DONE.
REQ-032 Operation enables and key_i are sampled at start and held internally.
REQ-033 Input changes during RUN have no effect.

Reset
REQ-034 rst_i asserted at any time, including mid-RUN, immediately clears the FSM to IDLE and clears state_o, cipher_o, tag_o, the round index and the held enables to 0.
REQ-035 While rst_i is asserted, busy_o, done_o and error_o are 0.
REQ-036 An aborted run produces no done_o pulse.

Structure
REQ-037 type_state (5x64), the round-constant function and the legal-round-count constants live in ascon_pack.
REQ-038 One sub-module, ascon_round, implements a single combinational round from state and round index.
REQ-039 The engine instantiates ascon_round UNROLL times in a chain.

Verification
REQ-040 UNROLL=1, nb_rounds=12, load=1, state_i=0, no enables -> done_o on cycle 13; state_o equals the golden-model p12(0).
REQ-041 UNROLL=2, nb_rounds=6 -> done_o on cycle 4; UNROLL=3, nb_rounds=8 -> error_o pulse, busy_o stays 0.
REQ-042 Ascon-128 KAT Count=1 (key and nonce 000102..0F, empty AD/PT) sequenced through the engine (init p12 with end-key, lsb domain separation, final with begin/end key) -> tag_o = E355159F292911F794CB1432A0103A8A.
REQ-043 en_replace_data=1 with data_i=0xDEADBEEFCAFEF00D -> cipher_o = data_i XOR old x0; post-permutation x0 is computed from data_i.
REQ-044 start_i pulsed on cycle 3 of a 12-round run -> ignored; exactly one done_o.
REQ-045 rst_i raised on cycle 5 of a run -> all outputs 0 within the same cycle, no done_o; the next start runs normally.
